// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX-stage issue logic and muldiv_unit.
interface muldiv_unit_if #(
    parameter int DATA_SIZE = 32,
    parameter int OP_SIZE   = 3
);
    logic                 i_start;
    logic [OP_SIZE-1:0]   i_op;
    logic [DATA_SIZE-1:0] i_A;
    logic [DATA_SIZE-1:0] i_B;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_stall;
    logic [DATA_SIZE-1:0] o_hi;
    logic [DATA_SIZE-1:0] o_lo;

    modport master (
        output i_start, i_op, i_A, i_B,
        input  o_busy, o_done, o_stall, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_A, i_B,
        output o_busy, o_done, o_stall, o_hi, o_lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO writes.
// MULDIV_FAST_MUL_EN: multiplies complete in one cycle (IDLE -> FIX).
module muldiv_unit #(
    parameter int DATA_SIZE = 32,
    parameter int OP_SIZE   = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    muldiv_unit_if.slave bus
);
    localparam int D  = DATA_SIZE;
    localparam int CW = $clog2(DATA_SIZE + 1);
    localparam logic [OP_SIZE-1:0] OP_MULT  = OP_SIZE'(0);
    localparam logic [OP_SIZE-1:0] OP_MULTU = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] OP_DIV   = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] OP_DIVU  = OP_SIZE'(3);
    localparam logic [OP_SIZE-1:0] OP_MTHI  = OP_SIZE'(4);
    localparam logic [OP_SIZE-1:0] OP_MTLO  = OP_SIZE'(5);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [2*D-1:0] acc;
    logic [D-1:0]  mag_b, a_raw, hi, lo;
    logic          is_div, neg_res, neg_rem, div_zero, busy, done;

    logic          req_md, accept, is_signed, a_neg, b_neg, fast_mul;
    logic [D-1:0]  mag_a_in, mag_b_in, q, r;
    logic [D:0]    mul_sum, div_shift, div_diff;
    logic [2*D-1:0] prod_fix;

    assign req_md    = bus.i_start && (bus.i_op <= OP_DIVU);
    assign accept    = (state == IDLE) && req_md;
    assign is_signed = (bus.i_op == OP_MULT) || (bus.i_op == OP_DIV);
    assign a_neg     = is_signed && bus.i_A[D-1];
    assign b_neg     = is_signed && bus.i_B[D-1];
    assign mag_a_in  = a_neg ? -bus.i_A : bus.i_A;
    assign mag_b_in  = b_neg ? -bus.i_B : bus.i_B;
`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul  = (bus.i_op == OP_MULT) || (bus.i_op == OP_MULTU);
`else
    assign fast_mul  = 1'b0;
`endif

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc[2*D-1:D]} + (acc[0] ? {1'b0, mag_b} : '0);
    assign div_shift = {acc[2*D-1:D], acc[D-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign q         = acc[D-1:0];
    assign r         = acc[2*D-1:D];
    assign prod_fix  = neg_res ? -acc : acc;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = fast_mul ? FIX : RUN;
            RUN:     if (cnt == CW'(1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt <= '0; acc <= '0; mag_b <= '0; a_raw <= '0; hi <= '0; lo <= '0;
            is_div <= 1'b0; neg_res <= 1'b0; neg_rem <= 1'b0; div_zero <= 1'b0;
            busy <= 1'b0; done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mag_b    <= mag_b_in;
                        a_raw    <= bus.i_A;
                        is_div   <= (bus.i_op == OP_DIV) || (bus.i_op == OP_DIVU);
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= (bus.i_B == '0);
                        busy     <= 1'b1;
                        cnt      <= CW'(D);
`ifdef MULDIV_FAST_MUL_EN
                        if (fast_mul) acc <= {{D{1'b0}}, mag_a_in} * {{D{1'b0}}, mag_b_in};
                        else          acc <= {{D{1'b0}}, mag_a_in};
`else
                        acc      <= {{D{1'b0}}, mag_a_in};
`endif
                    end else if (bus.i_start && bus.i_op == OP_MTHI) begin
                        hi <= bus.i_A;
                    end else if (bus.i_start && bus.i_op == OP_MTLO) begin
                        lo <= bus.i_A;
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (is_div)
                        acc <= {div_diff[D] ? div_shift[D-1:0] : div_diff[D-1:0],
                                acc[D-2:0], ~div_diff[D]};
                    else
                        acc <= {mul_sum, acc[D-1:1]};
                end
                FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (!is_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (div_zero) begin
                        lo <= '1;
                        hi <= a_raw;
                    end else begin
                        lo <= neg_res ? -q : q;
                        hi <= neg_rem ? -r : r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy  = busy;
    assign bus.o_done  = done;
    assign bus.o_stall = busy | req_md;
    assign bus.o_hi    = hi;
    assign bus.o_lo    = lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO queued at issue, checked at o_done.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if bus();
    muldiv_unit dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    typedef struct { logic [31:0] hi; logic [31:0] lo; } exp_t;
    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    // Drive a request for one cycle at a negedge; returns the request-cycle stall.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, output logic stall_req);
        exp_t e;
        e.hi = ehi; e.lo = elo;
        sb.push_back(e);
        bus.i_start = 1'b1; bus.i_op = op; bus.i_A = a; bus.i_B = b;
        #1 stall_req = bus.o_stall;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    // Waits (bounded) for o_done; leaves the bench at the negedge where o_done is seen.
    task automatic wait_done(output int lat, output int stall_cnt, output bit hold_bad,
                             output bit timeout);
        logic [31:0] h0, l0;
        h0 = bus.o_hi; l0 = bus.o_lo;
        lat = 1; stall_cnt = 0; hold_bad = 0; timeout = 0;
        while (bus.o_done !== 1'b1) begin
            if (bus.o_busy === 1'b1) begin
                if (bus.o_stall === 1'b1) stall_cnt++;
                if (bus.o_hi !== h0 || bus.o_lo !== l0) hold_bad = 1;
            end
            if (lat >= 200) begin
                timeout = 1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0; bus.i_op = '0; bus.i_A = '0; bus.i_B = '0;
        repeat (2) @(negedge clk);
        tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
        tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.o_done); end
        tests++; if (bus.o_hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want 0", bus.o_hi); end
        tests++; if (bus.o_lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want 0", bus.o_lo); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu();
        logic s; int lat, sc; bit hb, to; exp_t e;
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, s);
        wait_done(lat, sc, hb, to);
        e = sb.pop_front();
        tests++; if (to || lat != MUL_LAT) begin fails++; $display("FAIL multu_latency got %0d want %0d", lat, MUL_LAT); end
        tests++; if (bus.o_hi !== e.hi) begin fails++; $display("FAIL multu_hi got %h want %h", bus.o_hi, e.hi); end
        tests++; if (bus.o_lo !== e.lo) begin fails++; $display("FAIL multu_lo got %h want %h", bus.o_lo, e.lo); end
        @(negedge clk);
        tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL multu_done_pulse got %b want 0", bus.o_done); end
    endtask

    task automatic test_mult_stall();
        logic s; int lat, sc; bit hb, to; exp_t e;
        issue(3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, s);
        wait_done(lat, sc, hb, to);
        e = sb.pop_front();
        tests++; if (s !== 1'b1) begin fails++; $display("FAIL mult_stall_req got %b want 1", s); end
        tests++; if (to || sc + 1 != MUL_LAT) begin fails++; $display("FAIL mult_stall_window got %0d want %0d", sc + 1, MUL_LAT); end
        tests++; if (hb) begin fails++; $display("FAIL mult_hold got changed want held"); end
        tests++; if (bus.o_hi !== e.hi) begin fails++; $display("FAIL mult_hi got %h want %h", bus.o_hi, e.hi); end
        tests++; if (bus.o_lo !== e.lo) begin fails++; $display("FAIL mult_lo got %h want %h", bus.o_lo, e.lo); end
        @(negedge clk);
        tests++; if (bus.o_stall !== 1'b0) begin fails++; $display("FAIL mult_stall_after got %b want 0", bus.o_stall); end
    endtask

    task automatic test_div();
        logic s; int lat, sc; bit hb, to; exp_t e;
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, s);
        wait_done(lat, sc, hb, to);
        e = sb.pop_front();
        tests++; if (to || lat != DIV_LAT) begin fails++; $display("FAIL div_latency got %0d want %0d", lat, DIV_LAT); end
        tests++; if (bus.o_hi !== e.hi || bus.o_lo !== e.lo) begin fails++; $display("FAIL div_neg got %h_%h want %h_%h", bus.o_hi, bus.o_lo, e.hi, e.lo); end
        @(negedge clk);
        issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, s);
        wait_done(lat, sc, hb, to);
        e = sb.pop_front();
        tests++; if (to || bus.o_hi !== e.hi || bus.o_lo !== e.lo) begin fails++; $display("FAIL divu got %h_%h want %h_%h", bus.o_hi, bus.o_lo, e.hi, e.lo); end
        @(negedge clk);
    endtask

    task automatic test_div_edge();
        logic s; int lat, sc; bit hb, to; exp_t e;
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, s);
        wait_done(lat, sc, hb, to);
        e = sb.pop_front();
        tests++; if (to || bus.o_hi !== e.hi || bus.o_lo !== e.lo) begin fails++; $display("FAIL div_overflow got %h_%h want %h_%h", bus.o_hi, bus.o_lo, e.hi, e.lo); end
        @(negedge clk);
        issue(3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, s);
        wait_done(lat, sc, hb, to);
        e = sb.pop_front();
        tests++; if (to || lat != DIV_LAT) begin fails++; $display("FAIL divzero_latency got %0d want %0d", lat, DIV_LAT); end
        tests++; if (bus.o_hi !== e.hi || bus.o_lo !== e.lo) begin fails++; $display("FAIL divzero got %h_%h want %h_%h", bus.o_hi, bus.o_lo, e.hi, e.lo); end
        @(negedge clk);
        issue(3'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, s);
        wait_done(lat, sc, hb, to);
        e = sb.pop_front();
        tests++; if (to || bus.o_hi !== e.hi || bus.o_lo !== e.lo) begin fails++; $display("FAIL divzero_signed got %h_%h want %h_%h", bus.o_hi, bus.o_lo, e.hi, e.lo); end
        @(negedge clk);
    endtask

    task automatic test_mt();
        bus.i_start = 1'b1; bus.i_op = 3'd4; bus.i_A = 32'h12345678;
        #1;
        tests++; if (bus.o_stall !== 1'b0) begin fails++; $display("FAIL mthi_stall got %b want 0", bus.o_stall); end
        @(negedge clk);
        bus.i_op = 3'd5; bus.i_A = 32'h9ABCDEF0;
        tests++; if (bus.o_hi !== 32'h12345678) begin fails++; $display("FAIL mthi got %h want 12345678", bus.o_hi); end
        @(negedge clk);
        bus.i_start = 1'b0;
        tests++; if (bus.o_lo !== 32'h9ABCDEF0) begin fails++; $display("FAIL mtlo got %h want 9abcdef0", bus.o_lo); end
        tests++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin fails++; $display("FAIL mt_handshake got busy=%b done=%b want 0 0", bus.o_busy, bus.o_done); end
        @(negedge clk);
        tests++; if (bus.o_done !== 1'b0 || bus.o_hi !== 32'h12345678) begin fails++; $display("FAIL mt_after got done=%b hi=%h want 0 12345678", bus.o_done, bus.o_hi); end
    endtask

    task automatic test_back_to_back();
        logic s; int lat, sc; bit hb, to; exp_t e;
        issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, s);
        wait_done(lat, sc, hb, to);
        e = sb.pop_front();
        tests++; if (to || bus.o_hi !== e.hi || bus.o_lo !== e.lo) begin fails++; $display("FAIL b2b_first got %h_%h want %h_%h", bus.o_hi, bus.o_lo, e.hi, e.lo); end
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, s);
        tests++; if (s !== 1'b1 || bus.o_busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got stall=%b busy=%b want 1 1", s, bus.o_busy); end
        wait_done(lat, sc, hb, to);
        e = sb.pop_front();
        tests++; if (to || lat != DIV_LAT) begin fails++; $display("FAIL b2b_latency got %0d want %0d", lat, DIV_LAT); end
        tests++; if (bus.o_hi !== e.hi || bus.o_lo !== e.lo) begin fails++; $display("FAIL b2b_second got %h_%h want %h_%h", bus.o_hi, bus.o_lo, e.hi, e.lo); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic s; int lat, sc; bit hb, to; exp_t e;
        issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, s);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", bus.o_busy); end
        tests++; if (bus.o_hi !== 32'h0 || bus.o_lo !== 32'h0) begin fails++; $display("FAIL abort_hilo got %h_%h want 0_0", bus.o_hi, bus.o_lo); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(3'd3, 32'd9, 32'd3, 32'd0, 32'd3, s);
        wait_done(lat, sc, hb, to);
        e = sb.pop_front();
        tests++; if (to || lat != DIV_LAT) begin fails++; $display("FAIL post_reset_latency got %0d want %0d", lat, DIV_LAT); end
        tests++; if (bus.o_hi !== e.hi || bus.o_lo !== e.lo) begin fails++; $display("FAIL post_reset_divu got %h_%h want %h_%h", bus.o_hi, bus.o_lo, e.hi, e.lo); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_stall();
        test_div();
        test_div_edge();
        test_mt();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit in the EX stage, beside the combinational ALU. It executes MULT, MULTU, DIV and DIVU over many cycles and owns the architectural HI/LO registers. It also services MTHI/MTLO writes. A start/busy/done handshake and a combinational stall output freeze the pipeline while an operation is in flight, and the MFHI/MFLO path reads HI/LO directly.

## Interface
- DATA_SIZE, 32, operand/HI/LO width; iteration count equals DATA_SIZE
- OP_SIZE, 3, width of operation code
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- i_start  in  1  request; sampled on rising edge
- i_op  in  OP_SIZE  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, others=no-op
- i_A  in  DATA_SIZE  rs operand (multiplicand/dividend/MT data)
- i_B  in  DATA_SIZE  rt operand (multiplier/divisor)
- o_busy  out  1  registered; operation in flight
- o_done  out  1  registered; one-cycle pulse when HI/LO updated by mult/div
- o_stall  out  1  combinational: o_busy | (i_start & i_op in 0..3)
- o_hi  out  DATA_SIZE  HI register
- o_lo  out  DATA_SIZE  LO register

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE with i_start and op 0..3 -> RUN:
  - latch magnitudes of i_A/i_B; signed ops take the two's-complement absolute value
  - latch the result sign flags
  - iteration counter = DATA_SIZE
  - o_busy <= 1
- RUN: one iteration per cycle, counter decrements.
  - Multiply: shift-add into a 2*DATA_SIZE product.
  - Divide: restoring shift-subtract, remainder and quotient.
  - Counter reaching 0 -> FIX.
- FIX: apply sign correction, write HI/LO, o_busy <= 0, o_done <= 1 -> IDLE.
- Product sign: MULT negates the 64-bit product when operand signs differ.
- Quotient sign: DIV quotient sign = sign(A) ^ sign(B); remainder sign = sign(A).
- Result mapping:
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = dividend (i_A as latched, unsigned raw value); full latency still taken.
- Signed overflow: DIV -2^31 / -1 -> LO = 0x80000000, HI = 0.
- MTHI/MTLO in IDLE: HI or LO <= i_A at the sampling edge.
  - o_busy stays 0, no o_done, no stall.
- i_start while o_busy: ignored, no state change; the pipeline is stalled, so this does not occur legally.
- Op codes 6/7: ignored.

## Timing
- Reset values: o_busy = 0, o_done = 0, o_hi = 0, o_lo = 0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately; HI/LO return to 0.
- Mult/div accepted at edge T0:
  - o_busy = 1 after T0 through edge T32 (RUN iterations at T1..T32)
  - FIX at edge T33 writes HI/LO, drops o_busy and sets o_done
  - o_done = 1 for exactly the cycle after T33
- Stall window: o_stall high in the request cycle (combinationally) and while o_busy is high, i.e. 34 cycles total.
- Back-to-back: a new i_start is accepted in the cycle o_done is high, since o_busy is already 0.
- MTHI/MTLO: o_hi/o_lo update visible the cycle after the sampling edge.
- o_hi/o_lo hold their old values throughout RUN; no partial results are exposed.

## Configuration
- MULDIV_FAST_MUL_EN
  - Defined: MULT/MULTU compute with a single-cycle full-width multiply. Acceptance edge T0 goes IDLE -> FIX. HI/LO written at T1, o_busy high one cycle, o_done the cycle after T1.
  - Undefined: MULT/MULTU iterate as above (33-edge latency).
  - DIV/DIVU are identical in both builds.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; o_done exactly 34 cycles after request (2 with MULDIV_FAST_MUL_EN).
- MULT A=-3 (0xFFFFFFFD), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; o_stall high the whole busy window.
- DIV A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU A=100, B=7 -> LO=14, HI=2.
- DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0. DIVU A=5, B=0 -> LO=0xFFFFFFFF, HI=5.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> o_hi/o_lo updated next cycle, o_busy never set, o_done never pulses.
- i_reset low at RUN iteration 10 -> o_busy=0, o_hi=o_lo=0 immediately. After release, a new DIVU 9/3 completes normally with LO=3, HI=0.
